// File: rtl/uart_rx_sampler.sv
// Oversampled UART receiver: start detect, mid-bit sampling, stop check; even parity when UART_RX_PARITY_EN is defined.
// Latency ~(1.5 + DATA_BITS [+1]) bit times from start edge plus 3 clk; no backpressure, rx_valid is a 1-clk pulse.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt;
  logic                 perr_q, perr_nxt;
`endif

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_nxt;
      perr_q    <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            // A start bit that is already high again at mid-bit was noise.
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            par_nxt   = rx_s;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_nxt  = par_bit ^ (^shift);
`endif
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      BREAK: begin
        // Held-low line: stay here so a long break reports only one error.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8 data bits, 16x oversample, s_tick every 4 clk (64 clk per bit).
module tb_uart_rx_sampler;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int tests = 0;
  int fails = 0;

  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_busy_valid = 0;
  logic [7:0] got_q[$];
  logic       perr_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      s_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        n_valid++;
        got_q.push_back(rx_data);
        perr_q.push_back(parity_err);
        if (busy !== 1'b0) n_busy_valid++;
      end
      if (frame_err === 1'b1) n_ferr++;
      if (parity_err === 1'b1) n_perr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int bits);
    rx = 1'b1;
    repeat (bits * BIT_CLK) @(negedge clk);
  endtask

  function automatic logic [7:0] q_at(input int idx);
    logic [7:0] v;
    v = 8'hxx;
    if (got_q.size() > idx) v = got_q[idx];
    return v;
  endfunction

  initial begin : main
    int bv, bf, bp, bq;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'hC3, 1'b0, 8'hA5, 0, 1};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
    vecs[3] = '{8'h96, 1'b1, 8'h96, 1, 0};

    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    idle_bits(1);

    for (int i = 0; i < 4; i++) begin
      bv = n_valid; bf = n_ferr; bq = got_q.size();
      send_frame(vecs[i].d, ^vecs[i].d, vecs[i].stop);
      idle_bits(2);
      check($sformatf("vec%0d_valid_cnt", i), n_valid - bv, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr_cnt", i), n_ferr - bf, vecs[i].exp_ferr);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
      if (vecs[i].exp_valid > 0) check($sformatf("vec%0d_byte", i), q_at(bq), vecs[i].d);
    end

    // Start glitch of 5 ticks, then a clean 0x3C frame.
    bv = n_valid; bf = n_ferr; bq = got_q.size();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid_cnt", n_valid - bv, 0);
    check("glitch_ferr_cnt", n_ferr - bf, 0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle_bits(2);
    check("post_glitch_valid_cnt", n_valid - bv, 1);
    check("post_glitch_byte", q_at(bq), 8'h3C);

    // 0x5A with low stop bit, line held low 40 bit times.
    bv = n_valid; bf = n_ferr; bq = got_q.size();
    send_frame(8'h5A, ^8'h5A, 1'b0);
    rx = 1'b0;
    repeat (39 * BIT_CLK) @(negedge clk);
    check("break_busy", busy, 1'b1);
    idle_bits(2);
    check("break_ferr_cnt", n_ferr - bf, 1);
    check("break_valid_cnt", n_valid - bv, 0);
    check("break_rx_data_held", rx_data, 8'h3C);
    check("break_busy_after", busy, 1'b0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle_bits(2);
    check("break_recover_byte", q_at(bq), 8'h5A);

    // Back-to-back frames with no idle gap.
    bv = n_valid; bq = got_q.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(2);
    check("b2b_valid_cnt", n_valid - bv, 2);
    check("b2b_byte0", q_at(bq), 8'h00);
    check("b2b_byte1", q_at(bq + 1), 8'hFF);
    check("b2b_rx_data", rx_data, 8'hFF);

    // Reset in the middle of data bit 4.
    bv = n_valid; bf = n_ferr; bq = got_q.size();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    check("mid_data_busy", busy, 1'b1);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    check("rst_mid_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    idle_bits(2);
    check("rst_mid_no_pulse", (n_valid - bv) + (n_ferr - bf), 0);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle_bits(2);
    check("rst_recover_byte", q_at(bq), 8'h81);
    check("rst_recover_rx_data", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    bv = n_valid; bp = n_perr; bq = got_q.size();
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    check("par_bad_valid_cnt", n_valid - bv, 1);
    check("par_bad_byte", q_at(bq), 8'h07);
    check("par_bad_perr_with_valid", (perr_q.size() > bq) ? perr_q[bq] : 1'bx, 1'b1);
    check("par_bad_perr_cnt", n_perr - bp, 1);
    bp = n_perr; bq = got_q.size();
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check("par_good_byte", q_at(bq), 8'h07);
    check("par_good_perr_cnt", n_perr - bp, 0);
`else
    bp = 0;
    check("no_parity_perr_cnt", n_perr - bp, 0);
`endif

    check("busy_low_at_every_valid", n_busy_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
